// File: rtl/data_cache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// One word per line; the core holds its request while stall is high.
module data_cache_responder #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_re,
    input  logic [3:0]  cpu_we,
    input  logic [31:0] cpu_din,
    output logic [31:0] cpu_dout,
    output logic        stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_rw,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    output logic [3:0]  mem_req_mask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MREQ  = 2'd1;
    localparam logic [1:0] MWAIT = 2'd2;
    localparam logic [1:0] WREQ  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             req_valid_q, req_valid_d;
    logic [31:2]      req_addr_q, req_addr_d;
    logic [3:0]       req_we_q, req_we_d;
    logic [31:0]      req_din_q, req_din_d;
    logic [31:0]      dout_q, dout_d;
    logic [LINES-1:0] valid_q, valid_d;

    logic [TAG_W-1:0] tag_q [LINES];
    logic [31:0]      data_q [LINES];

    logic                  data_we;
    logic                  tag_we;
    logic [31:0]           data_wdata;
    logic [31:0]           merged;
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic [31:0]           line_data;
    logic                  hit;
    logic                  is_write;
    logic                  rd_hit;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr[1:0];

    assign idx       = req_addr_q[INDEX_BITS+1:2];
    assign tag       = req_addr_q[31:INDEX_BITS+2];
    assign line_data = data_q[idx];
    assign hit       = valid_q[idx] && (tag_q[idx] == tag);
    assign is_write  = (req_we_q != 4'b0000);
    assign rd_hit    = (state_q == IDLE) && req_valid_q
                       && !is_write && hit;

    always_comb begin
        merged = line_data;
        for (int b = 0; b < 4; b++) begin
            if (req_we_q[b]) begin
                merged[8*b +: 8] = req_din_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        req_valid_d   = req_valid_q;
        req_addr_d    = req_addr_q;
        req_we_d      = req_we_q;
        req_din_d     = req_din_q;
        dout_d        = dout_q;
        valid_d       = valid_q;
        data_we       = 1'b0;
        tag_we        = 1'b0;
        data_wdata    = merged;
        stall         = 1'b1;
        mem_req_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall = req_valid_q && !rd_hit;
                if (rd_hit) begin
                    dout_d = line_data;
                end
                if (req_valid_q && is_write) begin
                    data_we = hit;
                    state_d = WREQ;
                end else if (req_valid_q && !hit) begin
                    state_d = MREQ;
                end
            end
            MREQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = MWAIT;
                end
            end
            MWAIT: begin
                if (mem_resp_valid) begin
                    data_we      = 1'b1;
                    tag_we       = 1'b1;
                    data_wdata   = mem_resp_data;
                    valid_d[idx] = 1'b1;
                    state_d      = IDLE;
                end
            end
            WREQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!stall) begin
            req_valid_d = cpu_re || (cpu_we != 4'b0000);
            req_addr_d  = cpu_addr[31:2];
            req_we_d    = cpu_we;
            req_din_d   = cpu_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_we_q    <= '0;
            req_din_q   <= '0;
            dout_q      <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_we_q    <= req_we_d;
            req_din_q   <= req_din_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
        end
    end

    // Tag/data arrays are never reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[idx] <= data_wdata;
        end
        if (tag_we) begin
            tag_q[idx] <= tag;
        end
    end

    assign cpu_dout     = rd_hit ? line_data : dout_q;
    assign mem_req_rw   = (state_q == WREQ);
    assign mem_req_addr = {req_addr_q, 2'b00};
    assign mem_req_data = req_din_q;
    assign mem_req_mask = req_we_q;

endmodule
